// File: rtl/tlb_pkg.sv
// Shared op codes, TLBELO field layout and FSM states for the TLB maintenance sequencer.
package tlb_pkg;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam int ELO_V      = 0;
  localparam int ELO_D      = 1;
  localparam int ELO_PLV_LO = 2;
  localparam int ELO_MAT_LO = 4;
  localparam int ELO_G      = 6;
  localparam int ELO_PPN_LO = 7;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  localparam logic [4:0] INV_OP_MAX = 5'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [26:0] pack_elo(input logic [19:0] ppn, input logic g,
                                           input logic [1:0] mat, input logic [1:0] plv,
                                           input logic d, input logic v);
    return {ppn, g, mat, plv, d, v};
  endfunction

endpackage

// File: rtl/tlb_fill_cnt.sv
// Free-running TLBFILL victim index; advances every cycle and wraps at TLBNUM.
module tlb_fill_cnt #(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] idx_q;

  // TLBNUM is a power of two, so natural overflow gives the wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) idx_q <= '0;
    else         idx_q <= idx_q + 1'b1;
  end

  assign idx = idx_q;

endmodule

// File: rtl/tlb_ctrl.sv
// TLB maintenance sequencer: latches one request, drives the TLB ports for one
// cycle, then presents registered CSR update results for one cycle.
module tlb_ctrl
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [4:0]    req_inv_op,
  input  logic [9:0]    req_inv_asid,
  input  logic [18:0]   req_inv_vppn,
  input  logic [9:0]    csr_asid,
  input  logic [18:0]   csr_ehi_vppn,
  input  logic [IW-1:0] csr_idx_index,
  input  logic [5:0]    csr_idx_ps,
  input  logic          csr_idx_ne,
  input  logic [26:0]   csr_elo0,
  input  logic [26:0]   csr_elo1,
  output logic [18:0]   tlb_s1_vppn,
  output logic          tlb_s1_va_bit12,
  output logic [9:0]    tlb_s1_asid,
  input  logic          tlb_s1_found,
  input  logic [IW-1:0] tlb_s1_index,
  output logic          tlb_invtlb_valid,
  output logic [4:0]    tlb_invtlb_op,
  output logic          tlb_we,
  output logic [IW-1:0] tlb_w_index,
  output logic          tlb_w_e,
  output logic [18:0]   tlb_w_vppn,
  output logic [5:0]    tlb_w_ps,
  output logic [9:0]    tlb_w_asid,
  output logic          tlb_w_g,
  output logic [19:0]   tlb_w_ppn0,
  output logic [1:0]    tlb_w_plv0,
  output logic [1:0]    tlb_w_mat0,
  output logic          tlb_w_d0,
  output logic          tlb_w_v0,
  output logic [19:0]   tlb_w_ppn1,
  output logic [1:0]    tlb_w_plv1,
  output logic [1:0]    tlb_w_mat1,
  output logic          tlb_w_d1,
  output logic          tlb_w_v1,
  output logic [IW-1:0] tlb_r_index,
  input  logic          tlb_r_e,
  input  logic [18:0]   tlb_r_vppn,
  input  logic [5:0]    tlb_r_ps,
  input  logic [9:0]    tlb_r_asid,
  input  logic          tlb_r_g,
  input  logic [19:0]   tlb_r_ppn0,
  input  logic [1:0]    tlb_r_plv0,
  input  logic [1:0]    tlb_r_mat0,
  input  logic          tlb_r_d0,
  input  logic          tlb_r_v0,
  input  logic [19:0]   tlb_r_ppn1,
  input  logic [1:0]    tlb_r_plv1,
  input  logic [1:0]    tlb_r_mat1,
  input  logic          tlb_r_d1,
  input  logic          tlb_r_v1,
  output logic          done,
  output logic          done_ine,
  output logic          upd_idx_we,
  output logic [IW-1:0] upd_index,
  output logic          upd_ne,
  output logic [5:0]    upd_ps,
  output logic          upd_entry_we,
  output logic [18:0]   upd_ehi_vppn,
  output logic [26:0]   upd_elo0,
  output logic [26:0]   upd_elo1,
  output logic [9:0]    upd_asid
);

  state_e        state_q, state_d;
  logic [IW-1:0] fill_idx;
  logic          accept, exec, inv_sel, is_write, inv_legal;

  logic [2:0]    op_q;
  logic [4:0]    inv_op_q;
  logic [9:0]    inv_asid_q, asid_q;
  logic [18:0]   inv_vppn_q, vppn_q;
  logic [IW-1:0] idx_q, fill_q;
  logic [5:0]    ps_q;
  logic          ne_q;
  logic [26:0]   elo0_q, elo1_q;

  logic          done_ine_q, upd_idx_we_q, upd_entry_we_q, upd_ne_q;
  logic [IW-1:0] upd_index_q;
  logic [5:0]    upd_ps_q;
  logic [18:0]   upd_vppn_q;
  logic [26:0]   upd_elo0_q, upd_elo1_q;
  logic [9:0]    upd_asid_q;

  tlb_fill_cnt #(.TLBNUM(TLBNUM)) u_fill_cnt (
    .clk    (clk),
    .resetn (resetn),
    .idx    (fill_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    tlb_we           = 1'b0;
    tlb_invtlb_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        tlb_we           = is_write;
        tlb_invtlb_valid = inv_sel & inv_legal;
        state_d          = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept    = req_valid & req_ready;
  assign exec      = (state_q == ST_EXEC);
  assign inv_sel   = (op_q == OP_INV);
  assign is_write  = (op_q == OP_WR) | (op_q == OP_FILL);
  assign inv_legal = (inv_op_q <= INV_OP_MAX);

  // Everything the TLB sees comes from this snapshot, so late CSR writes cannot leak in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q       <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      asid_q     <= '0;
      vppn_q     <= '0;
      idx_q      <= '0;
      ps_q       <= '0;
      ne_q       <= 1'b0;
      elo0_q     <= '0;
      elo1_q     <= '0;
      fill_q     <= '0;
    end else if (accept) begin
      op_q       <= req_op;
      inv_op_q   <= req_inv_op;
      inv_asid_q <= req_inv_asid;
      inv_vppn_q <= req_inv_vppn;
      asid_q     <= csr_asid;
      vppn_q     <= csr_ehi_vppn;
      idx_q      <= csr_idx_index;
      ps_q       <= csr_idx_ps;
      ne_q       <= csr_idx_ne;
      elo0_q     <= csr_elo0;
      elo1_q     <= csr_elo1;
      fill_q     <= fill_idx;
    end
  end

  assign tlb_s1_vppn     = inv_sel ? inv_vppn_q : vppn_q;
  assign tlb_s1_asid     = inv_sel ? inv_asid_q : asid_q;
  assign tlb_s1_va_bit12 = 1'b0;
  assign tlb_invtlb_op   = inv_op_q;
  assign tlb_r_index     = idx_q;

  assign tlb_w_index = (op_q == OP_FILL) ? fill_q : idx_q;
  assign tlb_w_e     = tlb_we & ~ne_q;
  assign tlb_w_vppn  = vppn_q;
  assign tlb_w_ps    = ps_q;
  assign tlb_w_asid  = asid_q;
  assign tlb_w_g     = elo0_q[ELO_G] & elo1_q[ELO_G];
  assign tlb_w_ppn0  = elo0_q[ELO_PPN_LO +: 20];
  assign tlb_w_plv0  = elo0_q[ELO_PLV_LO +: 2];
  assign tlb_w_mat0  = elo0_q[ELO_MAT_LO +: 2];
  assign tlb_w_d0    = elo0_q[ELO_D];
  assign tlb_w_v0    = elo0_q[ELO_V];
  assign tlb_w_ppn1  = elo1_q[ELO_PPN_LO +: 20];
  assign tlb_w_plv1  = elo1_q[ELO_PLV_LO +: 2];
  assign tlb_w_mat1  = elo1_q[ELO_MAT_LO +: 2];
  assign tlb_w_d1    = elo1_q[ELO_D];
  assign tlb_w_v1    = elo1_q[ELO_V];

  // Results are captured at the end of EXEC; the write enables self-clear the cycle after.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_ine_q     <= 1'b0;
      upd_idx_we_q   <= 1'b0;
      upd_entry_we_q <= 1'b0;
      upd_ne_q       <= 1'b0;
      upd_index_q    <= '0;
      upd_ps_q       <= '0;
      upd_vppn_q     <= '0;
      upd_elo0_q     <= '0;
      upd_elo1_q     <= '0;
      upd_asid_q     <= '0;
    end else begin
      done_ine_q     <= exec & inv_sel & ~inv_legal;
      upd_idx_we_q   <= exec & ((op_q == OP_SRCH) | (op_q == OP_RD));
      upd_entry_we_q <= exec & (op_q == OP_RD);
      if (exec && op_q == OP_SRCH) begin
        upd_index_q <= tlb_s1_found ? tlb_s1_index : idx_q;
        upd_ne_q    <= ~tlb_s1_found;
      end
      if (exec && op_q == OP_RD) begin
        upd_index_q <= idx_q;
        upd_ne_q    <= ~tlb_r_e;
        upd_ps_q    <= {6{tlb_r_e}} & tlb_r_ps;
        upd_vppn_q  <= {19{tlb_r_e}} & tlb_r_vppn;
        upd_asid_q  <= {10{tlb_r_e}} & tlb_r_asid;
        upd_elo0_q  <= {27{tlb_r_e}} &
                       pack_elo(tlb_r_ppn0, tlb_r_g, tlb_r_mat0, tlb_r_plv0, tlb_r_d0, tlb_r_v0);
        upd_elo1_q  <= {27{tlb_r_e}} &
                       pack_elo(tlb_r_ppn1, tlb_r_g, tlb_r_mat1, tlb_r_plv1, tlb_r_d1, tlb_r_v1);
      end
    end
  end

  assign done         = (state_q == ST_DONE);
  assign done_ine     = done_ine_q;
  assign upd_idx_we   = upd_idx_we_q;
  assign upd_entry_we = upd_entry_we_q;
  assign upd_index    = upd_index_q;
  assign upd_ne       = upd_ne_q;
  assign upd_ps       = upd_ps_q;
  assign upd_ehi_vppn = upd_vppn_q;
  assign upd_elo0     = upd_elo0_q;
  assign upd_elo1     = upd_elo1_q;
  assign upd_asid     = upd_asid_q;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl: a behavioural 16-entry TLB answers the DUT's ports, and each
// request's expected TLB drive and CSR results are derived per request from the op rules.
module tb_tlb_ctrl;
  import tlb_pkg::*;

  localparam int TLBNUM = 16;

  logic clk = 1'b0;
  logic resetn;
  logic req_valid, req_ready;
  logic [2:0] req_op;
  logic [4:0] req_inv_op;
  logic [9:0] req_inv_asid, csr_asid;
  logic [18:0] req_inv_vppn, csr_ehi_vppn;
  logic [3:0] csr_idx_index;
  logic [5:0] csr_idx_ps;
  logic csr_idx_ne;
  logic [26:0] csr_elo0, csr_elo1;
  logic [18:0] tlb_s1_vppn;
  logic tlb_s1_va_bit12;
  logic [9:0] tlb_s1_asid;
  logic tlb_s1_found;
  logic [3:0] tlb_s1_index;
  logic tlb_invtlb_valid;
  logic [4:0] tlb_invtlb_op;
  logic tlb_we, tlb_w_e, tlb_w_g, tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
  logic [3:0] tlb_w_index, tlb_r_index;
  logic [18:0] tlb_w_vppn, tlb_r_vppn;
  logic [5:0] tlb_w_ps, tlb_r_ps;
  logic [9:0] tlb_w_asid, tlb_r_asid;
  logic [19:0] tlb_w_ppn0, tlb_w_ppn1, tlb_r_ppn0, tlb_r_ppn1;
  logic [1:0] tlb_w_plv0, tlb_w_mat0, tlb_w_plv1, tlb_w_mat1;
  logic [1:0] tlb_r_plv0, tlb_r_mat0, tlb_r_plv1, tlb_r_mat1;
  logic tlb_r_e, tlb_r_g, tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
  logic done, done_ine, upd_idx_we, upd_ne, upd_entry_we;
  logic [3:0] upd_index;
  logic [5:0] upd_ps;
  logic [18:0] upd_ehi_vppn;
  logic [26:0] upd_elo0, upd_elo1;
  logic [9:0] upd_asid;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [26:0] lo0;
    logic [26:0] lo1;
  } ent_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vppn;
    logic [9:0]  asid;
    logic [18:0] vppn;
    logic [3:0]  idx;
    logic [5:0]  ps;
    logic        ne;
    logic [26:0] elo0;
    logic [26:0] elo1;
  } req_t;

  ent_t   mem [TLBNUM];
  int     n_chk = 0;
  int     n_err = 0;
  longint t_rel;
  logic [3:0] last_fill, cap_widx, cap_index;
  logic [5:0] cap_ps;
  logic       cap_ne;
  logic [3:0] fw0, fw1, fw2;
  req_t r;

  always #5 clk = ~clk;

  tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid),
    .req_inv_vppn(req_inv_vppn), .csr_asid(csr_asid), .csr_ehi_vppn(csr_ehi_vppn),
    .csr_idx_index(csr_idx_index), .csr_idx_ps(csr_idx_ps), .csr_idx_ne(csr_idx_ne),
    .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
    .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_va_bit12(tlb_s1_va_bit12), .tlb_s1_asid(tlb_s1_asid),
    .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
    .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_invtlb_op(tlb_invtlb_op),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn),
    .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
    .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0), .tlb_w_mat0(tlb_w_mat0),
    .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0),
    .tlb_w_ppn1(tlb_w_ppn1), .tlb_w_plv1(tlb_w_plv1), .tlb_w_mat1(tlb_w_mat1),
    .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1),
    .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_vppn(tlb_r_vppn),
    .tlb_r_ps(tlb_r_ps), .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
    .tlb_r_ppn0(tlb_r_ppn0), .tlb_r_plv0(tlb_r_plv0), .tlb_r_mat0(tlb_r_mat0),
    .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0),
    .tlb_r_ppn1(tlb_r_ppn1), .tlb_r_plv1(tlb_r_plv1), .tlb_r_mat1(tlb_r_mat1),
    .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1),
    .done(done), .done_ine(done_ine), .upd_idx_we(upd_idx_we), .upd_index(upd_index),
    .upd_ne(upd_ne), .upd_ps(upd_ps), .upd_entry_we(upd_entry_we),
    .upd_ehi_vppn(upd_ehi_vppn), .upd_elo0(upd_elo0), .upd_elo1(upd_elo1), .upd_asid(upd_asid)
  );

  // Behavioural TLB: write port, lowest-index-wins search, combinational read.
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) mem[i] <= '0;
    end else if (tlb_we) begin
      mem[tlb_w_index] <= {tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g,
                           tlb_w_ppn0, tlb_w_g, tlb_w_mat0, tlb_w_plv0, tlb_w_d0, tlb_w_v0,
                           tlb_w_ppn1, tlb_w_g, tlb_w_mat1, tlb_w_plv1, tlb_w_d1, tlb_w_v1};
    end
  end

  always_comb begin
    tlb_s1_found = 1'b0;
    tlb_s1_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (mem[i].e && mem[i].vppn == tlb_s1_vppn && (mem[i].g || mem[i].asid == tlb_s1_asid)) begin
        tlb_s1_found = 1'b1;
        tlb_s1_index = 4'(i);
      end
    end
  end

  assign tlb_r_e    = mem[tlb_r_index].e;
  assign tlb_r_vppn = mem[tlb_r_index].vppn;
  assign tlb_r_ps   = mem[tlb_r_index].ps;
  assign tlb_r_asid = mem[tlb_r_index].asid;
  assign tlb_r_g    = mem[tlb_r_index].g;
  assign {tlb_r_ppn0, tlb_r_mat0, tlb_r_plv0, tlb_r_d0, tlb_r_v0} =
         {mem[tlb_r_index].lo0[26:7], mem[tlb_r_index].lo0[5:0]};
  assign {tlb_r_ppn1, tlb_r_mat1, tlb_r_plv1, tlb_r_d1, tlb_r_v1} =
         {mem[tlb_r_index].lo1[26:7], mem[tlb_r_index].lo1[5:0]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_find(input logic [18:0] vppn, input logic [9:0] asid);
    for (int i = 0; i < TLBNUM; i++)
      if (mem[i].e && mem[i].vppn == vppn && (mem[i].g || mem[i].asid == asid)) return i;
    return -1;
  endfunction

  task automatic drive(input req_t q);
    req_valid = 1'b1;        req_op = q.op;          req_inv_op = q.inv_op;
    req_inv_asid = q.inv_asid; req_inv_vppn = q.inv_vppn; csr_asid = q.asid;
    csr_ehi_vppn = q.vppn;   csr_idx_index = q.idx;  csr_idx_ps = q.ps;
    csr_idx_ne = q.ne;       csr_elo0 = q.elo0;      csr_elo1 = q.elo1;
  endtask

  task automatic scramble();
    req_op = 3'($urandom);        req_inv_op = 5'($urandom);   req_inv_asid = 10'($urandom);
    req_inv_vppn = 19'($urandom); csr_asid = 10'($urandom);    csr_ehi_vppn = 19'($urandom);
    csr_idx_index = 4'($urandom); csr_idx_ps = 6'($urandom);   csr_idx_ne = 1'($urandom);
    csr_elo0 = 27'($urandom);     csr_elo1 = 27'($urandom);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the cycle after done.
  task automatic issue(input req_t q);
    longint t_acc;
    int hit;
    ent_t ent;
    logic is_wr, exp_inv, exp_ine;
    logic [26:0] exp_lo0, exp_lo1;
    drive(q);
    chk("ready_idle", req_ready, 1'b1);
    @(posedge clk);
    t_acc = longint'($time);
    last_fill = 4'((t_acc - t_rel - 5) / 10);
    @(negedge clk);
    req_valid = 1'b0;
    scramble();
    is_wr   = (q.op == OP_WR) || (q.op == OP_FILL);
    exp_inv = (q.op == OP_INV) && (q.inv_op <= 5'd6);
    exp_ine = (q.op == OP_INV) && (q.inv_op > 5'd6);
    cap_widx = tlb_w_index;
    chk("exec_done", done, 1'b0);
    chk("exec_we", tlb_we, is_wr);
    chk("exec_invtlb", tlb_invtlb_valid, exp_inv);
    chk("va_bit12", tlb_s1_va_bit12, 1'b0);
    if (is_wr) begin
      chk("w_index", tlb_w_index, (q.op == OP_FILL) ? last_fill : q.idx);
      chk("w_e", tlb_w_e, !q.ne);
      chk("w_ps", tlb_w_ps, q.ps);
      chk("w_vppn_asid", {tlb_w_vppn, tlb_w_asid}, {q.vppn, q.asid});
      chk("w_g", tlb_w_g, q.elo0[6] & q.elo1[6]);
      chk("w_lo0", {tlb_w_ppn0, tlb_w_mat0, tlb_w_plv0, tlb_w_d0, tlb_w_v0},
          {q.elo0[26:7], q.elo0[5:0]});
      chk("w_lo1", {tlb_w_ppn1, tlb_w_mat1, tlb_w_plv1, tlb_w_d1, tlb_w_v1},
          {q.elo1[26:7], q.elo1[5:0]});
    end
    if (exp_inv) chk("invtlb_op", tlb_invtlb_op, q.inv_op);
    if (q.op == OP_SRCH) chk("s1_srch", {tlb_s1_vppn, tlb_s1_asid}, {q.vppn, q.asid});
    if (q.op == OP_INV) chk("s1_inv", {tlb_s1_vppn, tlb_s1_asid}, {q.inv_vppn, q.inv_asid});
    hit = model_find(q.vppn, q.asid);
    ent = mem[q.idx];
    @(negedge clk);
    cap_index = upd_index;
    cap_ps    = upd_ps;
    cap_ne    = upd_ne;
    chk("done", done, 1'b1);
    chk("done_ine", done_ine, exp_ine);
    chk("idx_we", upd_idx_we, (q.op == OP_SRCH) || (q.op == OP_RD));
    chk("entry_we", upd_entry_we, q.op == OP_RD);
    chk("done_quiet", {tlb_we, tlb_invtlb_valid, req_ready}, 3'b000);
    if (q.op == OP_SRCH) begin
      chk("srch_index", upd_index, (hit >= 0) ? 4'(hit) : q.idx);
      chk("srch_ne", upd_ne, hit < 0);
    end
    if (q.op == OP_RD) begin
      exp_lo0 = ent.e ? {ent.lo0[26:7], ent.g, ent.lo0[5:0]} : 27'd0;
      exp_lo1 = ent.e ? {ent.lo1[26:7], ent.g, ent.lo1[5:0]} : 27'd0;
      chk("rd_ne", upd_ne, !ent.e);
      chk("rd_ps_vppn_asid", {upd_ps, upd_ehi_vppn, upd_asid},
          ent.e ? {ent.ps, ent.vppn, ent.asid} : 35'd0);
      chk("rd_elo", {upd_elo0, upd_elo1}, {exp_lo0, exp_lo1});
    end
    @(negedge clk);
    chk("idle_done", done, 1'b0);
    chk("idle_upd_we", {upd_idx_we, upd_entry_we, done_ine}, 3'b000);
    chk("idle_ready", req_ready, 1'b1);
  endtask

  initial begin
    resetn = 1'b0;
    req_valid = 1'b0;
    scramble();
    #3;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_pulses", {done, done_ine, tlb_we, tlb_invtlb_valid, tlb_w_e}, 5'b0);
    chk("rst_upd_we", {upd_idx_we, upd_entry_we, upd_ne}, 3'b0);
    chk("rst_drive", {tlb_s1_vppn, tlb_s1_asid, tlb_r_index, tlb_w_index}, 37'd0);
    chk("rst_upd", {upd_index, upd_ps, upd_ehi_vppn, upd_asid}, 39'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    t_rel = longint'($time);

    // Preload entry 5 (non-global, asid 3), then hit and miss it.
    r = '0; r.op = OP_WR; r.idx = 4'd5; r.vppn = 19'h12345; r.asid = 10'd3; r.ps = PS_4K;
    r.elo0 = 27'h2a_0011; r.elo1 = 27'h13_0023;
    issue(r);
    r = '0; r.op = OP_SRCH; r.vppn = 19'h12345; r.asid = 10'd3; r.idx = 4'd9;
    issue(r);
    chk("srch_hit_idx5", {cap_index, cap_ne}, {4'd5, 1'b0});
    r.asid = 10'd4; r.idx = 4'd11;
    issue(r);
    chk("srch_miss_keep", {cap_index, cap_ne}, {4'd11, 1'b1});

    // WR index 7 with mixed g, then read it back.
    r = '0; r.op = OP_WR; r.idx = 4'd7; r.ne = 1'b0; r.ps = PS_2M; r.vppn = 19'h0abcd;
    r.asid = 10'h155; r.elo0 = 27'h7ff_ff7f; r.elo1 = 27'h000_00bf;
    issue(r);
    chk("wr7_index", cap_widx, 4'd7);
    r = '0; r.op = OP_RD; r.idx = 4'd7;
    issue(r);
    chk("rd7_ps", {cap_ps, cap_ne}, {PS_2M, 1'b0});
    r.idx = 4'd9;
    issue(r);
    chk("rd_invalid_ne", cap_ne, 1'b1);

    // Three back-to-back fills land three counter steps apart.
    r = '0; r.op = OP_FILL; r.vppn = 19'h00777; r.asid = 10'd1; r.ps = PS_4K; r.elo0 = 27'h55;
    issue(r); fw0 = cap_widx;
    issue(r); fw1 = cap_widx;
    issue(r); fw2 = cap_widx;
    chk("fill_step_a", 4'(fw1 - fw0), 4'd3);
    chk("fill_step_b", 4'(fw2 - fw1), 4'd3);

    r = '0; r.op = OP_INV; r.inv_op = 5'd3; r.inv_asid = 10'h2aa; r.inv_vppn = 19'h4_5678;
    issue(r);
    r.inv_op = 5'd6; issue(r);
    r.inv_op = 5'd7; issue(r);
    r = '0; r.op = 3'd6; issue(r);

    // Reset in the EXEC cycle of a WR.
    r = '0; r.op = OP_WR; r.idx = 4'd2; r.vppn = 19'h7777; r.elo0 = 27'h41; r.elo1 = 27'h41;
    drive(r);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_we_pre", tlb_we, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_we_async", tlb_we, 1'b0);
    chk("rst_mid_ready", req_ready, 1'b1);
    @(negedge clk);
    chk("rst_mid_no_done", done, 1'b0);
    resetn = 1'b1;
    t_rel = longint'($time);
    @(negedge clk);
    chk("rst_mid_no_done2", {done, upd_idx_we, upd_entry_we}, 3'b000);
    chk("rst_mid_ready2", req_ready, 1'b1);

    // Random traffic over a small vppn/asid space so searches both hit and miss.
    for (int k = 0; k < 60; k++) begin
      r.op       = 3'($urandom_range(0, 7));
      r.inv_op   = 5'($urandom_range(0, 9));
      r.inv_asid = 10'($urandom);
      r.inv_vppn = 19'($urandom);
      r.asid     = 10'($urandom_range(0, 1));
      r.vppn     = ($urandom_range(0, 3) != 0) ? 19'($urandom_range(0, 3)) : 19'($urandom);
      r.idx      = 4'($urandom);
      r.ps       = ($urandom_range(0, 1) != 0) ? PS_2M : PS_4K;
      r.ne       = ($urandom_range(0, 3) == 0);
      r.elo0     = 27'($urandom);
      r.elo1     = 27'($urandom);
      issue(r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tlb_ctrl.md
# tlb_ctrl

Sequencer for the TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB), sitting directly upstream of the `TLBNUM`-entry TLB. It takes one request from the execute stage and drives the TLB's search port 1, read port, write port and invtlb port from the CSR shadow values. It returns CSR update results one cycle after the TLB access. It also owns the pseudo-random index used by TLBFILL.

## Interface
- `TLBNUM`, 16: TLB entry count, a power of two. `IW = $clog2(TLBNUM)`.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_op` in 3: operation code. 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; codes 5–7 are reserved.
- `req_inv_op` in 5, `req_inv_asid` in 10, `req_inv_vppn` in 19: INVTLB operands.
- `csr_asid` in 10, `csr_ehi_vppn` in 19: current CSR.ASID and TLBEHI.VPPN.
- `csr_idx_index` in IW, `csr_idx_ps` in 6, `csr_idx_ne` in 1: current TLBIDX fields.
- `csr_elo0`, `csr_elo1` in 27: packed as {ppn[19:0], g, mat[1:0], plv[1:0], d, v}.
- `tlb_s1_vppn` out 19, `tlb_s1_va_bit12` out 1, `tlb_s1_asid` out 10: search port 1 drive.
- `tlb_s1_found` in 1, `tlb_s1_index` in IW: search port 1 result.
- `tlb_invtlb_valid` out 1, `tlb_invtlb_op` out 5: invtlb port.
- `tlb_we` out 1, plus `tlb_w_index`, `tlb_w_e`, `tlb_w_vppn`, `tlb_w_ps`, `tlb_w_asid`, `tlb_w_g`, `tlb_w_{ppn,plv,mat,d,v}{0,1}` out: the write port, at TLB widths.
- `tlb_r_index` out IW, plus `tlb_r_*` in: the read port, at TLB widths.
- `done` out 1: completion pulse. `done_ine` out 1: reserved INVTLB op.
- `upd_idx_we` out 1, `upd_index` out IW, `upd_ne` out 1, `upd_ps` out 6: TLBIDX update.
- `upd_entry_we` out 1, `upd_ehi_vppn` out 19, `upd_elo0` out 27, `upd_elo1` out 27, `upd_asid` out 10: TLBEHI/TLBELO/ASID update.

## Operation
- **State machine: IDLE → EXEC → DONE → IDLE.**
  - `req_ready` = (state == IDLE).
  - On accept, the request and CSR inputs are latched into registers.
  - All `tlb_*` drives come only from those latched registers, never from live inputs.
- **EXEC by op:**
  - **SRCH:** `tlb_s1_vppn` = ehi_vppn and `tlb_s1_asid` = csr_asid. Sample found/index at the end of EXEC.
  - **RD:** `tlb_r_index` = idx_index. Sample the `tlb_r_*` fields.
  - **WR:** `tlb_we` = 1 with `w_index` = idx_index, `w_e` = !idx_ne, `w_ps` = idx_ps, `w_asid` = csr_asid, `w_g` = elo0.g & elo1.g, and the remaining fields unpacked from elo0/elo1.
  - **FILL:** same as WR, except `w_index` = the fill counter value latched at accept.
  - **INV:** `tlb_s1_asid` = inv_asid and `tlb_s1_vppn` = inv_vppn. If inv_op ≤ 6, assert `tlb_invtlb_valid` with `tlb_invtlb_op` = inv_op. If inv_op > 6, do not touch the TLB and set `done_ine`.
  - Reserved `req_op` (5–7): treated as a no-op that still completes with `done`.
  - `tlb_s1_va_bit12` = 0 always.
- **DONE results:**
  - **SRCH hit:** `upd_idx_we` = 1, `upd_index` = hit index, `upd_ne` = 0.
  - **SRCH miss:** `upd_idx_we` = 1, `upd_ne` = 1, `upd_index` = latched idx_index (unchanged).
  - **RD, r_e = 1:** `upd_idx_we` = `upd_entry_we` = 1, `upd_ne` = 0, and ps/vppn/asid/elo0/elo1 come from the entry (elo g = r_g in both).
  - **RD, r_e = 0:** `upd_ne` = 1, and `upd_ps`, `upd_ehi_vppn`, `upd_elo*`, `upd_asid` are all 0.
  - **WR/FILL/INV:** only `done` (and `done_ine` for a reserved INVTLB op).
- **Fill counter:** IW bits, reset to 0, increments every cycle regardless of state, wraps from TLBNUM-1 to 0.

## Timing
- Accept at cycle t (IDLE, valid & ready). EXEC is cycle t+1. `done` is high in cycle t+2 only. The next accept is possible at t+3.
- `tlb_we` and `tlb_invtlb_valid` are single-cycle pulses in EXEC, at most one per request. They are never asserted in the same cycle.
- The `upd_*` outputs are registered and valid only while `done` = 1. Outside that cycle the `upd_*_we` signals are 0.
- Reset value of every output is 0, except `req_ready` = 1.
- Reset asserted mid-operation:
  - State returns to IDLE and the in-flight op is dropped.
  - No `done` is issued.
  - `tlb_we` and `tlb_invtlb_valid` deassert immediately (asynchronously).
- CSR inputs changing after accept have no effect on the op in flight.

## Structure
- **Shared package `tlb_pkg`:**
  - op code constants (SRCH..INV);
  - ELO bit offsets (V = 0, D = 1, PLV = 3:2, MAT = 5:4, G = 6, PPN = 26:7);
  - PS constants 12 and 21;
  - the maximum legal INVTLB op, 6.
- **Sub-module `tlb_fill_cnt`:** the free-running wrap counter, parameter TLBNUM, output `idx`.

## Test plan
- **SRCH hit:** entry 5 holds vppn 0x12345 / asid 3, and the request has ehi_vppn 0x12345, asid 3 → at t+2 `done`, `upd_idx_we`, `upd_index` = 5, `upd_ne` = 0.
- **SRCH miss:** no entry matches → `upd_ne` = 1, `upd_index` = the latched idx_index.
- **WR:** idx_index 7, ne 0, ps 21, elo0.g = 1, elo1.g = 0 → one-cycle `tlb_we` at t+1 with `w_index` 7, `w_e` 1, `w_ps` 21, `w_g` 0; a following RD of index 7 returns r_ps 21.
- **RD of an invalid entry:** → `upd_ne` = 1, `upd_entry_we` = 1, and all entry fields 0.
- **FILL three times back-to-back:** each `w_index` equals the counter value at its accept; consecutive indices differ by 3 mod TLBNUM.
- **INV op 7, and reset during EXEC of a WR:**
  - INV op 7 → no `tlb_invtlb_valid`, `done` with `done_ine` = 1.
  - Reset during EXEC of a WR → `tlb_we` drops, no `done`, `req_ready` = 1 after release.
